// File: rtl/sram_fifo_flagged.sv
// -----------------------------------------------------------------------------
// sram_fifo_flagged
// Synchronous FIFO on an inferred single-clock dual-port RAM. It provides
// registered occupancy, full/empty, programmable almost-full/almost-empty
// flags and sticky overflow/underflow error bits.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        write request, accepted only while full=0
//   wr_data      write data, sampled on the accepting edge
//   rd_en        read request, accepted only while empty=0
//   rd_data      read data, valid the cycle after an accepted read
//   rd_valid     one-cycle strobe marking a newly read word on rd_data
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AFULL_TH
//   almost_empty count <= AEMPTY_TH
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//   clr_err      synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sram_fifo_flagged #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int                 DEPTH       = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C     = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_C       = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0] ZERO_C      = (ADDR_BITS + 1)'(0);
    localparam logic [ADDR_BITS:0] AFULL_C     = (ADDR_BITS + 1)'(AFULL_TH);
    localparam logic [ADDR_BITS:0] AEMPTY_C    = (ADDR_BITS + 1)'(AEMPTY_TH);
    localparam logic               AFULL_RST_C = (AFULL_TH == 0) ? 1'b1 : 1'b0;

    // Storage; deliberately not reset so it maps onto plain RAM.
    logic [WIDTH-1:0]   mem_r [DEPTH];

    // Pointers carry a wrap bit above the RAM index.
    logic [ADDR_BITS:0] wrPtr_r;
    logic [ADDR_BITS:0] rdPtr_r;

    logic               wrAccept_s;
    logic               rdAccept_s;
    logic [ADDR_BITS:0] countNext_s;

    // Handshake acceptance: gated by the registered flags, so a write
    // while full is rejected even if a read frees a slot in the same cycle.
    always_comb begin
        wrAccept_s = wr_en & ~full;
        rdAccept_s = rd_en & ~empty;
    end

    // Next occupancy; every flag is registered from this value so the
    // flags change in the same cycle as count.
    always_comb begin
        countNext_s = count;
        case ({wrAccept_s, rdAccept_s})
            2'b10:   countNext_s = count + ONE_C;
            2'b01:   countNext_s = count - ONE_C;
            default: countNext_s = count;
        endcase
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wrAccept_s) begin
            mem_r[wrPtr_r[ADDR_BITS-1:0]] <= wr_data;
        end else begin
            mem_r[wrPtr_r[ADDR_BITS-1:0]] <= mem_r[wrPtr_r[ADDR_BITS-1:0]];
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r      <= ZERO_C;
            rdPtr_r      <= ZERO_C;
            count        <= ZERO_C;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AFULL_RST_C;
            almost_empty <= 1'b1;
        end else begin
            wrPtr_r      <= wrAccept_s ? (wrPtr_r + ONE_C) : wrPtr_r;
            rdPtr_r      <= rdAccept_s ? (rdPtr_r + ONE_C) : rdPtr_r;
            count        <= countNext_s;
            full         <= (countNext_s == DEPTH_C);
            empty        <= (countNext_s == ZERO_C);
            almost_full  <= (countNext_s >= AFULL_C);
            almost_empty <= (countNext_s <= AEMPTY_C);
        end
    end

    // Read port with one-cycle latency; rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= {WIDTH{1'b0}};
            rd_valid <= 1'b0;
        end else if (rdAccept_s) begin
            rd_data  <= mem_r[rdPtr_r[ADDR_BITS-1:0]];
            rd_valid <= 1'b1;
        end else begin
            rd_data  <= rd_data;
            rd_valid <= 1'b0;
        end
    end

    // Sticky error bits; a new error event wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end else begin
                underflow <= underflow;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_flagged.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_flagged
// Self-checking bench for sram_fifo_flagged (WIDTH=8, DEPTH=8, AFULL_TH=6,
// AEMPTY_TH=1). A queue-based reference model tracks the FIFO contents;
// one compare process checks every output against it on each negedge, and
// the stimulus sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sram_fifo_flagged;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int nCmp = 0;
    int nErr = 0;

    // Reference model state.
    logic [7:0] q[$];
    logic [7:0] expData  = 8'h00;
    logic       expValid = 1'b0;
    logic       expOvf   = 1'b0;
    logic       expUnf   = 1'b0;
    bit         checkOn  = 1'b0;

    sram_fifo_flagged #(
        .WIDTH(8), .ADDR_BITS(3), .AFULL_TH(6), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, updated on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            expData  = 8'h00;
            expValid = 1'b0;
            expOvf   = 1'b0;
            expUnf   = 1'b0;
        end else begin
            bit wasFull;
            bit wasEmpty;
            wasFull  = (q.size() == DEPTH);
            wasEmpty = (q.size() == 0);
            if (rd_en && !wasEmpty) begin
                expData  = q.pop_front();
                expValid = 1'b1;
            end else begin
                expValid = 1'b0;
            end
            if (wr_en && !wasFull) q.push_back(wr_data);
            if (wr_en && wasFull) expOvf = 1'b1;
            else if (clr_err)     expOvf = 1'b0;
            if (rd_en && wasEmpty) expUnf = 1'b1;
            else if (clr_err)      expUnf = 1'b0;
        end
    end

    // Compare process: all outputs against the model, away from the edge.
    always @(negedge clk) begin
        if (checkOn && !rst) begin
            int n;
            n = q.size();
            chk("count",        32'(count),        32'(n));
            chk("full",         32'(full),         32'(n == DEPTH));
            chk("empty",        32'(empty),        32'(n == 0));
            chk("almost_full",  32'(almost_full),  32'(n >= 6));
            chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
            chk("rd_valid",     32'(rd_valid),     32'(expValid));
            chk("rd_data",      32'(rd_data),      32'(expData));
            chk("overflow",     32'(overflow),     32'(expOvf));
            chk("underflow",    32'(underflow),    32'(expUnf));
        end
    end

    // One clock of stimulus; inputs change 2 time units after the edge.
    task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit ce);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        #12;
        // Literal reset state.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        checkOn = 1'b1;

        // Fill 0x11..0x18, sweeping count up.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 6));
            chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 1));
        end
        chk("fill_full", 32'(full), 32'd1);

        // Write while full: rejected, overflow sets.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // Drain in order, sweeping count down.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(8'h11 + i));
            chk("drain_aempty", 32'(almost_empty), 32'((7 - i) <= 1));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Read while empty, then simultaneous read/write on empty.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_valid", 32'(rd_valid), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        cyc(1'b1, 8'h5C, 1'b1, 1'b0);
        chk("emp_rw_count", 32'(count), 32'd1);
        chk("emp_rw_valid", 32'(rd_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("emp_rw_data", 32'(rd_data), 32'h5C);
        chk("emp_rw_dvalid", 32'(rd_valid), 32'd1);
        // Error event beats clr_err in the same cycle.
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_priority", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_unf", 32'(underflow), 32'd0);

        // Fill to full, then read+write while full: only the read is taken.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw_count", 32'(count), 32'd7);
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("full_rw_no_aa", 32'(rd_data == 8'hAA), 32'd0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to 4 then stream 20 cycles: output lags input by 4 words.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 4; i < 24; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_count", 32'(count), 32'd4);
            chk("stream_data", 32'(rd_data), 32'(i - 4));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-operation with rd_valid high.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        wr_en = 1'b0; rd_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        #4;
        cyc(1'b1, 8'h3E, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data", 32'(rd_data), 32'h3E);
        chk("post_rst_valid", 32'(rd_valid), 32'd1);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = i / 300;
            if (phase[0]) cyc(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 35),
                              ($urandom_range(0, 99) < 5));
            else          cyc(($urandom_range(0, 99) < 35), 8'($urandom), ($urandom_range(0, 99) < 70),
                              ($urandom_range(0, 99) < 5));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
